// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size encodings, FSM state
// type and size decoding functions.
package lsu_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    return 3'(size_bytes(size) - 4'd1);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extraction with sign/zero
// extension, and sub-word store merge into a captured 64-bit word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      lane,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] merged
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] field_mask;
  logic [XLEN-1:0] lane_mask;
  logic [XLEN-1:0] raw;
  logic            sign;

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    shamt      = {lane, 3'b000};
    field_mask = '1;
    sign       = 1'b0;
    case (size)
      SZ_B:    field_mask = 64'h0000_0000_0000_00ff;
      SZ_H:    field_mask = 64'h0000_0000_0000_ffff;
      SZ_W:    field_mask = 64'h0000_0000_ffff_ffff;
      default: field_mask = '1;
    endcase

    raw = (word >> shamt) & field_mask;
    case (size)
      SZ_B:    sign = raw[7];
      SZ_H:    sign = raw[15];
      SZ_W:    sign = raw[31];
      default: sign = 1'b0;
    endcase

    // A double already fills the register, so it never needs extension.
    rdata = (is_unsigned || !sign) ? raw : (raw | ~field_mask);

    lane_mask = field_mask << shamt;
    merged    = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a 64-bit word memory; sub-word stores use
// read-modify-write. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            mem_E,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write,
  output logic            mem_read,
  input  logic [XLEN-1:0] mem_read_data
);

  state_t          state, state_next;
  logic            we_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [2:0]      lane_q;
  logic [XLEN-1:0] wdata_q;

  logic            accept;
  logic [2:0]      req_mask;
  logic [2:0]      req_lane;
  logic            req_misaligned;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign req_mask  = size_mask(req_size);
  assign req_lane  = req_addr[2:0] & ~req_mask;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  assign req_misaligned = |(req_addr[2:0] & req_mask);
  assign rsp_err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= req_misaligned;
    end
  end
`else
  assign req_misaligned = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  assign mem_read  = (state == RD);
  assign mem_write = (state == WR);
  assign mem_E     = mem_read || mem_write;
  assign rsp_valid = (state == RESP);

  lsu_align u_align (
    .word        (mem_read_data),
    .wdata       (wdata_q),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (load_data),
    .merged      (merged_word)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_misaligned)                 state_next = RESP;
          else if (req_we && req_size == SZ_D) state_next = WR;
          else                                 state_next = RD;
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is registered with non-blocking assignments so every flop
  // samples pre-edge values; reset is synchronous and overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      size_q         <= SZ_B;
      lane_q         <= '0;
      wdata_q        <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      rsp_rdata      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q           <= req_we;
        uns_q          <= req_unsigned;
        size_q         <= req_size;
        lane_q         <= req_lane;
        wdata_q        <= req_wdata;
        mem_address    <= {3'b000, req_addr[XLEN-1:3]};
        mem_write_data <= req_wdata;
        rsp_rdata      <= '0;
      end
      // Capture cycle: the memory word is only valid now, so both the merged
      // store word and the extracted load value are taken from it here.
      if (state == CAP) begin
        mem_write_data <= merged_word;
        if (!we_q) rsp_rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural 64-bit
// word memory attached to its memory port.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_E;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_read_data;

  logic [63:0] mem [0:15];
  int          wr_count = 0;
  int          rsp_count = 0;
  logic        both_seen = 1'b0;
  logic        e_bad = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_E          (mem_E),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem_read_data = '0;
  end

  // Behavioural memory: registered read, data valid the cycle after mem_read.
  always @(posedge clk) begin
    if (mem_E && mem_write) mem[mem_address[3:0]] <= mem_write_data;
    if (mem_E && mem_read)  mem_read_data <= mem[mem_address[3:0]];
    if (mem_E && mem_write) wr_count <= wr_count + 1;
    if (rsp_valid)          rsp_count <= rsp_count + 1;
    if (mem_write && mem_read) both_seen <= 1'b1;
    if (rst === 1'b0 && mem_E !== (mem_read | mem_write)) e_bad <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one request and record, per cycle after acceptance, when each
  // strobe and the response appear.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output int rd_c, output int wr_c, output int rsp_c,
                         output logic [63:0] rdata, output logic [63:0] addr_at,
                         output logic err, output logic ready_after);
    int waited = 0;
    rd_c = 0; wr_c = 0; rsp_c = 0;
    rdata = '0; addr_at = '0; err = 1'b0; ready_after = 1'b0;
    @(negedge clk);
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = ~addr; req_wdata = ~wdata;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read && rd_c == 0) begin rd_c = c; addr_at = mem_address; end
      if (mem_write && wr_c == 0) begin wr_c = c; addr_at = mem_address; end
      if (rsp_valid && rsp_c == 0) begin rsp_c = c; rdata = rsp_rdata; err = rsp_err; end
      if (rsp_c != 0 && c == rsp_c + 1) ready_after = req_ready;
    end
  endtask

  initial begin
    int rd_c, wr_c, rsp_c, w0, r0;
    logic [63:0] rdata, addr_at;
    logic err, ready_after;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_ready",     64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_mem_E",     64'(mem_E), 64'd0);
    check("reset_strobes",   64'({mem_read, mem_write}), 64'd0);
    check("reset_rsp_err",   64'(rsp_err), 64'd0);
    check("reset_mem_addr",  mem_address, 64'd0);
    check("reset_mem_wdata", mem_write_data, 64'd0);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Store double 0x0123456789ABCDEF at 0x18.
    run_req(1'b1, 2'b11, 1'b0, 64'h18, 64'h0123_4567_89AB_CDEF,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
    check("sd_no_read",   64'(rd_c), 64'd0);
    check("sd_wr_cycle",  64'(wr_c), 64'd1);
    check("sd_mem_addr",  addr_at, 64'd3);
    check("sd_rsp_cycle", 64'(rsp_c), 64'd2);
    check("sd_rdata",     rdata, 64'd0);
    check("sd_ready_next", 64'(ready_after), 64'd1);
    check("sd_mem_word",  mem[3], 64'h0123_4567_89AB_CDEF);

    // Load double back.
    run_req(1'b0, 2'b11, 1'b1, 64'h18, 64'h0,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
    check("ld_rd_cycle",  64'(rd_c), 64'd1);
    check("ld_mem_addr",  addr_at, 64'd3);
    check("ld_rsp_cycle", 64'(rsp_c), 64'd3);
    check("ld_rdata",     rdata, 64'h0123_4567_89AB_CDEF);

    // Store byte 0xAA at 0x1D: read-modify-write, upper wdata bits ignored.
    run_req(1'b1, 2'b00, 1'b0, 64'h1D, 64'hFFFF_FFFF_FFFF_FFAA,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
    check("sb_rd_cycle",  64'(rd_c), 64'd1);
    check("sb_wr_cycle",  64'(wr_c), 64'd3);
    check("sb_mem_addr",  addr_at, 64'd3);
    check("sb_rsp_cycle", 64'(rsp_c), 64'd4);
    check("sb_ready_next", 64'(ready_after), 64'd1);
    check("sb_mem_word",  mem[3], 64'h0123_AA67_89AB_CDEF);

    // Byte loads at 0x1D, signed and unsigned.
    run_req(1'b0, 2'b00, 1'b0, 64'h1D, 64'h0,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
    check("lb_rsp_cycle", 64'(rsp_c), 64'd3);
    check("lb_rdata",     rdata, 64'hFFFF_FFFF_FFFF_FFAA);
    run_req(1'b0, 2'b00, 1'b1, 64'h1D, 64'h0,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
    check("lbu_rdata",    rdata, 64'h0000_0000_0000_00AA);

    // Signed half at 0x1E (positive value).
    run_req(1'b0, 2'b01, 1'b0, 64'h1E, 64'h0,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
    check("lh_rdata",     rdata, 64'h0000_0000_0000_0123);

    // Word at 0x1A: misaligned.
    run_req(1'b0, 2'b10, 1'b0, 64'h1A, 64'h0,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_rsp_cycle", 64'(rsp_c), 64'd1);
    check("lw_mis_err",       64'(err), 64'd1);
    check("lw_mis_no_read",   64'(rd_c), 64'd0);
    check("lw_mis_rdata",     rdata, 64'd0);
`else
    check("lw_mis_rsp_cycle", 64'(rsp_c), 64'd3);
    check("lw_mis_err",       64'(err), 64'd0);
    check("lw_mis_rdata",     rdata, 64'hFFFF_FFFF_89AB_CDEF);
`endif

    // Upper word at 0x1C, unsigned.
    run_req(1'b0, 2'b10, 1'b1, 64'h1C, 64'h0,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
    check("lwu_hi_rdata", rdata, 64'h0000_0000_0123_AA67);

    // Half store into an empty word, then signed half load of a negative value.
    run_req(1'b1, 2'b01, 1'b0, 64'h12, 64'h1234_BEEF,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
    check("sh_mem_addr",  addr_at, 64'd2);
    check("sh_mem_word",  mem[2], 64'h0000_0000_BEEF_0000);
    run_req(1'b0, 2'b01, 1'b0, 64'h12, 64'h0,
            rd_c, wr_c, rsp_c, rdata, addr_at, err, ready_after);
    check("lh_neg_rdata", rdata, 64'hFFFF_FFFF_FFFF_BEEF);

    // Reset during CAP of a byte store aborts it without touching memory.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 64'h18; req_wdata = 64'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    w0 = wr_count; r0 = rsp_count;
    @(negedge clk);
    check("abort_c1_read", 64'(mem_read), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_write",  64'(mem_write), 64'd0);
    check("abort_no_rsp",    64'(rsp_valid), 64'd0);
    check("abort_ready_rst", 64'(req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);
    check("abort_write_count", 64'(wr_count - w0), 64'd0);
    check("abort_rsp_count",   64'(rsp_count - r0), 64'd0);
    check("abort_mem_word",    mem[3], 64'h0123_AA67_89AB_CDEF);

    check("strobes_exclusive", 64'(both_seen), 64'd0);
    check("mem_E_consistent",  64'(e_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit sitting directly upstream of `data_memory_64_bit`. It accepts one byte/half/word/double memory request at a time from the execute stage and drives the memory's `E`/`address`/`write_data`/`mem_write`/`mem_read` port. Sub-word stores are done as read-modify-write. Load data is lane-extracted and sign/zero-extended before a single-cycle response pulse back to the pipeline.

## Interface
- `XLEN`, 64, data and address width (fixed at 64; the memory is 64-bit word organised).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 double.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 64: extended load data; 0 for stores.
- `rsp_err` out 1: misaligned access (only with macro, see Configuration).
- `mem_E` out 1, `mem_address` out 64, `mem_write_data` out 64, `mem_write` out 1, `mem_read` out 1: memory port.
- `mem_read_data` in 64: memory read data, valid the cycle after `mem_read` is high.

## Operation
- FSM states: IDLE, RD, CAP, WR, RESP. `req_ready = (state==IDLE) && !rst`.
- Load: IDLE → RD → CAP → RESP → IDLE.
- Double store: IDLE → WR → RESP.
- Sub-word store: IDLE → RD → CAP → WR → RESP.
- Request fields are latched at acceptance. Later changes on `req_*` are ignored until the unit returns to IDLE.
- `mem_address = {3'b0, addr[63:3]}` (word index), held constant from RD/WR through the last memory cycle of the request.
- RD: `mem_read=1`. WR: `mem_write=1`. `mem_E=1` exactly when either strobe is high. The two strobes are never both high.
- CAP: capture `mem_read_data` into the word register.
- Lane select is little-endian. `lane = addr[2:0]`, and the byte at offset k is `word[8k+7:8k]`.
- Store merge: replace `size_bytes` bytes starting at `lane` with `req_wdata[8*size_bytes-1:0]`. All other bytes keep the captured word.
- Load extract: take `size_bytes` bytes from `lane`, then sign-extend (bit 8*size_bytes-1) or zero-extend to 64 bits. Double loads ignore `req_unsigned`.
- Reset values: state IDLE; `rsp_valid`, `rsp_err`, `mem_E`, `mem_write`, `mem_read` = 0; `rsp_rdata`, `mem_address`, `mem_write_data` = 0.
- Reset mid-operation: at the next edge the FSM returns to IDLE and all strobes drop.
  - Memory is modified only in WR, so an interrupted RMW store leaves the word untouched.
  - No `rsp_valid` is produced for the aborted request.

## Timing
- Acceptance edge = cycle 0.
- Load: `mem_read` high in cycle 1, data sampled at end of cycle 2, `rsp_valid` in cycle 3.
- Double store: `mem_write` high in cycle 1, `rsp_valid` in cycle 2.
- Sub-word store: `mem_read` in cycle 1, capture in cycle 2, `mem_write` in cycle 3, `rsp_valid` in cycle 4.
- `rsp_valid` is a one-cycle pulse with no backpressure. `rsp_rdata` and `rsp_err` are valid only while it is high.
- `req_ready` rises in the cycle after RESP. The earliest back-to-back acceptance is that cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: an access whose `addr` is not a multiple of `size_bytes` goes IDLE → RESP.
  - No memory strobes are issued.
  - `rsp_err=1`, `rsp_rdata=0`, `rsp_valid` in cycle 1.
- Not defined: `rsp_err` is tied to 0. The low address bits are force-aligned (`addr[2:0] & ~(size_bytes-1)`) before lane selection, and the normal flow runs.

## Structure
- Package `lsu_pkg` holds:
  - the size encoding constants (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`);
  - the FSM state typedef;
  - a `size_bytes` function.
- Sub-module `lsu_align` (combinational) performs lane extraction with extension and store merge. The top level holds the FSM, latches and memory-port registers.

## Test plan
- Store double 0x0123456789ABCDEF at addr 0x18 → `mem_write` in cycle 1 with `mem_address=3`; `rsp_valid` in cycle 2. A later load double of 0x18 returns 0x0123456789ABCDEF.
- Store byte 0xAA at 0x1D over that word → RD, CAP, then WR writes 0x0123AA6789ABCDEF; `rsp_valid` in cycle 4.
- Load byte 0x1D signed → 0xFFFFFFFFFFFFFFAA; unsigned → 0x00000000000000AA; `rsp_valid` in cycle 3.
- Load half at 0x1E signed (bytes 0x23, 0x01) → 0x0000000000000123.
- Load word at 0x1A:
  - with the macro → `rsp_err=1` in cycle 1, no `mem_read`;
  - without the macro → aligned to 0x18, returns 0xFFFFFFFF89ABCDEF.
- `rst` asserted during CAP of a byte store → no `mem_write`, no `rsp_valid`; memory word unchanged; `req_ready=1` the cycle after `rst` drops.
